// File: rtl/hack_data_mem.sv
// Hack CPU M-bus data memory: decodes RAM, screen port and keyboard register.
// Screen accesses go out over a valid/ready port and stall the CPU until accepted.
module hack_data_mem #(
    parameter int RAM_WORDS = 16384
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [14:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        scr_valid,
    output logic        scr_write,
    output logic [12:0] scr_addr,
    output logic [15:0] scr_wdata,
    input  logic        scr_ready,
    input  logic [15:0] scr_rdata,
    input  logic [7:0]  kbd_code
);

    localparam int          AW        = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
    localparam logic [14:0] RAM_LIMIT = 15'(RAM_WORDS);

    typedef enum logic [0:0] {
        IDLE,
        SCR_WAIT
    } state_t;

    state_t state_reg, state_next;

    logic [7:0]  kbd_meta_reg, kbd_sync_reg;
    logic [15:0] ram_mem [RAM_WORDS];
    logic [15:0] ram_rdata_reg;
    logic        rsp_valid_reg;
    logic        rsp_from_ram_reg;
    logic [15:0] rsp_data_reg;
    logic        scr_valid_reg;
    logic        scr_write_reg;
    logic [12:0] scr_addr_reg;
    logic [15:0] scr_wdata_reg;

    logic          sel_ram, sel_scr, sel_kbd, ram_hit, accept;
    logic [AW-1:0] ram_idx;

    assign sel_ram = ~req_addr[14];
    assign sel_scr = (req_addr[14:13] == 2'b10);
    assign sel_kbd = (req_addr == 15'h6000);
    assign ram_hit = sel_ram && ({1'b0, req_addr[13:0]} < RAM_LIMIT);
    assign ram_idx = req_addr[AW-1:0];

    assign req_ready = (state_reg == IDLE) && !reset;
    assign accept    = req_valid && req_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept && sel_scr) begin
                    state_next = SCR_WAIT;
                end
            end
            SCR_WAIT: begin
                if (scr_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Single-port RAM with registered read; contents survive reset.
    always_ff @(posedge clk) begin
        if (accept && ram_hit) begin
            if (req_write) begin
                ram_mem[ram_idx] <= req_wdata;
            end else begin
                ram_rdata_reg <= ram_mem[ram_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            kbd_meta_reg     <= 8'h00;
            kbd_sync_reg     <= 8'h00;
            rsp_valid_reg    <= 1'b0;
            rsp_from_ram_reg <= 1'b0;
            rsp_data_reg     <= 16'h0000;
            scr_valid_reg    <= 1'b0;
            scr_write_reg    <= 1'b0;
            scr_addr_reg     <= 13'h0000;
            scr_wdata_reg    <= 16'h0000;
        end else begin
            kbd_meta_reg  <= kbd_code;
            kbd_sync_reg  <= kbd_meta_reg;
            rsp_valid_reg <= 1'b0;

            if (accept && !req_write && !sel_scr) begin
                rsp_valid_reg    <= 1'b1;
                rsp_from_ram_reg <= ram_hit;
                rsp_data_reg     <= sel_kbd ? {8'h00, kbd_sync_reg} : 16'h0000;
            end

            if (accept && sel_scr) begin
                scr_valid_reg <= 1'b1;
                scr_write_reg <= req_write;
                scr_addr_reg  <= req_addr[12:0];
                scr_wdata_reg <= req_wdata;
            end

            if (state_reg == SCR_WAIT && scr_ready) begin
                scr_valid_reg <= 1'b0;
                if (!scr_write_reg) begin
                    rsp_valid_reg    <= 1'b1;
                    rsp_from_ram_reg <= 1'b0;
                    rsp_data_reg     <= scr_rdata;
                end
            end
        end
    end

    // RAM data stays in its own read register so the array maps onto block RAM.
    assign rsp_valid = rsp_valid_reg && !reset;
    assign rsp_rdata = rsp_from_ram_reg ? ram_rdata_reg : rsp_data_reg;
    assign scr_valid = scr_valid_reg;
    assign scr_write = scr_write_reg;
    assign scr_addr  = scr_addr_reg;
    assign scr_wdata = scr_wdata_reg;

endmodule

// File: tb/tb_hack_data_mem.sv
// Directed bench for hack_data_mem: one task per scenario, inline checks.
module tb_hack_data_mem;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_write;
    logic [14:0] req_addr;
    logic [15:0] req_wdata;
    logic        req_ready;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        scr_valid, scr_write;
    logic [12:0] scr_addr;
    logic [15:0] scr_wdata;
    logic        scr_ready;
    logic [15:0] scr_rdata;
    logic [7:0]  kbd_code;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hack_data_mem #(.RAM_WORDS(16384)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .scr_valid(scr_valid), .scr_write(scr_write), .scr_addr(scr_addr),
        .scr_wdata(scr_wdata), .scr_ready(scr_ready), .scr_rdata(scr_rdata),
        .kbd_code(kbd_code)
    );

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic w, input logic [14:0] a, input logic [15:0] d);
        req_valid = v;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
    endtask

    task automatic test_reset();
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        checks++; if (rsp_rdata !== 16'h0000) begin errors++; $display("FAIL reset_rsp_rdata: got %h want 0000", rsp_rdata); end
        checks++; if ({scr_valid, scr_write, scr_addr, scr_wdata} !== 31'h0) begin errors++; $display("FAIL reset_scr: got v=%b w=%b a=%h d=%h want all 0", scr_valid, scr_write, scr_addr, scr_wdata); end
        reset = 1'b0;
        step();
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL post_reset_req_ready: got %b want 1", req_ready); end
        $display("test_reset done");
    endtask

    task automatic test_ram();
        drive(1'b1, 1'b1, 15'h0010, 16'hBEEF);
        step();
        drive(1'b1, 1'b0, 15'h0010, 16'h0000);
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL ram_store_no_rsp: got %b want 0", rsp_valid); end
        step();
        drive(1'b0, 1'b0, 15'h0000, 16'h0000);
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL ram_load_valid: got %b want 1", rsp_valid); end
        checks++; if (rsp_rdata !== 16'hBEEF) begin errors++; $display("FAIL ram_load_data: got %h want beef", rsp_rdata); end
        step();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL ram_rsp_pulse: got %b want 0", rsp_valid); end
        checks++; if (rsp_rdata !== 16'hBEEF) begin errors++; $display("FAIL ram_rsp_hold: got %h want beef", rsp_rdata); end
        // top RAM word
        drive(1'b1, 1'b1, 15'h3FFF, 16'hC0DE);
        step();
        drive(1'b1, 1'b0, 15'h3FFF, 16'h0000);
        step();
        drive(1'b0, 1'b0, 15'h0000, 16'h0000);
        checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 16'hC0DE) begin errors++; $display("FAIL ram_top_word: got v=%b d=%h want v=1 d=c0de", rsp_valid, rsp_rdata); end
        step();
        $display("test_ram done");
    endtask

    task automatic test_pipelined();
        drive(1'b1, 1'b1, 15'h0001, 16'h1111);
        step();
        drive(1'b1, 1'b1, 15'h0002, 16'h2222);
        step();
        drive(1'b1, 1'b0, 15'h0001, 16'h0000);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL pipe_ready0: got %b want 1", req_ready); end
        step();
        drive(1'b1, 1'b0, 15'h0002, 16'h0000);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL pipe_ready1: got %b want 1", req_ready); end
        checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 16'h1111) begin errors++; $display("FAIL pipe_rsp0: got v=%b d=%h want v=1 d=1111", rsp_valid, rsp_rdata); end
        step();
        drive(1'b0, 1'b0, 15'h0000, 16'h0000);
        checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 16'h2222) begin errors++; $display("FAIL pipe_rsp1: got v=%b d=%h want v=1 d=2222", rsp_valid, rsp_rdata); end
        step();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL pipe_rsp_end: got %b want 0", rsp_valid); end
        $display("test_pipelined done");
    endtask

    task automatic test_screen_store();
        scr_ready = 1'b0;
        drive(1'b1, 1'b1, 15'h4020, 16'hA5A5);
        step();
        // CPU presents a RAM load while stalled; it must not be taken.
        drive(1'b1, 1'b0, 15'h0010, 16'h0000);
        for (int i = 0; i < 4; i++) begin
            checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL scr_st_ready[%0d]: got %b want 0", i, req_ready); end
            checks++; if ({scr_valid, scr_write, scr_addr, scr_wdata} !== {1'b1, 1'b1, 13'h0020, 16'hA5A5}) begin
                errors++; $display("FAIL scr_st_port[%0d]: got v=%b w=%b a=%h d=%h want v=1 w=1 a=0020 d=a5a5", i, scr_valid, scr_write, scr_addr, scr_wdata);
            end
            checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL scr_st_rsp[%0d]: got %b want 0", i, rsp_valid); end
            if (i == 3) scr_ready = 1'b1;
            step();
        end
        scr_ready = 1'b0;
        drive(1'b0, 1'b0, 15'h0000, 16'h0000);
        checks++; if (req_ready !== 1'b1 || scr_valid !== 1'b0) begin errors++; $display("FAIL scr_st_done: got ready=%b valid=%b want 1 0", req_ready, scr_valid); end
        step();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL scr_st_no_rsp: got %b want 0", rsp_valid); end
        $display("test_screen_store done");
    endtask

    task automatic test_screen_load();
        scr_ready = 1'b1;
        scr_rdata = 16'h1234;
        drive(1'b1, 1'b0, 15'h5FFF, 16'h0000);
        step();
        drive(1'b0, 1'b0, 15'h0000, 16'h0000);
        checks++; if (scr_valid !== 1'b1 || scr_write !== 1'b0 || scr_addr !== 13'h1FFF) begin errors++; $display("FAIL scr_ld_port: got v=%b w=%b a=%h want v=1 w=0 a=1fff", scr_valid, scr_write, scr_addr); end
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin errors++; $display("FAIL scr_ld_wait: got rsp=%b ready=%b want 0 0", rsp_valid, req_ready); end
        step();
        scr_rdata = 16'hDEAD;
        checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 16'h1234) begin errors++; $display("FAIL scr_ld_rsp: got v=%b d=%h want v=1 d=1234", rsp_valid, rsp_rdata); end
        checks++; if (scr_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL scr_ld_release: got valid=%b ready=%b want 0 1", scr_valid, req_ready); end
        // lowest screen address maps to offset 0
        drive(1'b1, 1'b1, 15'h4000, 16'h5555);
        step();
        drive(1'b0, 1'b0, 15'h0000, 16'h0000);
        checks++; if (scr_valid !== 1'b1 || scr_addr !== 13'h0000 || scr_wdata !== 16'h5555) begin errors++; $display("FAIL scr_base: got v=%b a=%h d=%h want v=1 a=0000 d=5555", scr_valid, scr_addr, scr_wdata); end
        checks++; if (rsp_rdata !== 16'h1234) begin errors++; $display("FAIL scr_ld_hold: got %h want 1234", rsp_rdata); end
        step();
        checks++; if (scr_valid !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL scr_base_done: got valid=%b rsp=%b want 0 0", scr_valid, rsp_valid); end
        scr_ready = 1'b0;
        $display("test_screen_load done");
    endtask

    task automatic test_kbd_unmapped();
        kbd_code = 8'h41;
        step();
        step();
        drive(1'b1, 1'b0, 15'h6000, 16'h0000);
        step();
        kbd_code = 8'h55;
        drive(1'b1, 1'b0, 15'h6000, 16'h0000);
        checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 16'h0041) begin errors++; $display("FAIL kbd_load: got v=%b d=%h want v=1 d=0041", rsp_valid, rsp_rdata); end
        step();
        // new code not yet through the synchronizer
        drive(1'b1, 1'b1, 15'h6000, 16'h9999);
        checks++; if (rsp_rdata !== 16'h0041) begin errors++; $display("FAIL kbd_sync_lag: got %h want 0041", rsp_rdata); end
        step();
        drive(1'b1, 1'b0, 15'h6000, 16'h0000);
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL kbd_store_no_rsp: got %b want 0", rsp_valid); end
        step();
        drive(1'b1, 1'b1, 15'h7000, 16'hFFFF);
        checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 16'h0055) begin errors++; $display("FAIL kbd_load2: got v=%b d=%h want v=1 d=0055", rsp_valid, rsp_rdata); end
        step();
        drive(1'b1, 1'b0, 15'h7000, 16'h0000);
        step();
        drive(1'b0, 1'b0, 15'h0000, 16'h0000);
        checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 16'h0000) begin errors++; $display("FAIL unmapped_load: got v=%b d=%h want v=1 d=0000", rsp_valid, rsp_rdata); end
        step();
        $display("test_kbd_unmapped done");
    endtask

    task automatic test_reset_mid();
        scr_ready = 1'b0;
        drive(1'b1, 1'b0, 15'h4100, 16'h0000);
        step();
        drive(1'b0, 1'b0, 15'h0000, 16'h0000);
        checks++; if (scr_valid !== 1'b1) begin errors++; $display("FAIL rst_mid_pending: got %b want 1", scr_valid); end
        reset = 1'b1;
        step();
        checks++; if (scr_valid !== 1'b0 || req_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_clear: got valid=%b ready=%b want 0 0", scr_valid, req_ready); end
        reset = 1'b0;
        scr_ready = 1'b1;
        scr_rdata = 16'h7777;
        step();
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready: got %b want 1", req_ready); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (rsp_valid !== 1'b0 || scr_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_quiet[%0d]: got rsp=%b valid=%b want 0 0", i, rsp_valid, scr_valid); end
            step();
        end
        scr_ready = 1'b0;
        // reset in the cycle following a load acceptance loses the response
        drive(1'b1, 1'b0, 15'h0010, 16'h0000);
        step();
        drive(1'b0, 1'b0, 15'h0000, 16'h0000);
        reset = 1'b1;
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_after_load: got %b want 0", rsp_valid); end
        step();
        reset = 1'b0;
        step();
        checks++; if (rsp_valid !== 1'b0 || rsp_rdata !== 16'h0000) begin errors++; $display("FAIL rst_after_load_lost: got v=%b d=%h want v=0 d=0000", rsp_valid, rsp_rdata); end
        $display("test_reset_mid done");
    endtask

    initial begin
        reset     = 1'b1;
        scr_ready = 1'b0;
        scr_rdata = 16'h0000;
        kbd_code  = 8'h00;
        drive(1'b0, 1'b0, 15'h0000, 16'h0000);
        repeat (3) step();
        test_reset();
        test_ram();
        test_pipelined();
        test_screen_store();
        test_screen_load();
        test_kbd_unmapped();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hack_data_mem.md
# hack_data_mem

Data-memory responder for the Hack CPU's M-bus. It accepts the load and store requests the CPU core issues against `M` and decodes the 15-bit Hack address space into three targets: on-chip RAM, a memory-mapped screen port, and the keyboard register. Read data returns on a separate response channel. Screen accesses are forwarded to an external video block through a valid/ready port, so this block can stall the CPU.

## Interface
Parameters:
- `RAM_WORDS`, default 16384: implemented RAM depth, in words, starting at 0x0000. Must be ≤ 16384.

Ports:
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high reset
- `req_valid`  in  1  CPU request present
- `req_write`  in  1  1 = store, 0 = load
- `req_addr`  in  15  Hack word address
- `req_wdata`  in  16  store data
- `req_ready`  out  1  request accepted this cycle when `req_valid & req_ready`
- `rsp_valid`  out  1  one-cycle pulse, load data valid
- `rsp_rdata`  out  16  load data
- `scr_valid`  out  1  screen request pending
- `scr_write`  out  1  screen request is a store
- `scr_addr`  out  13  screen word offset, equal to `req_addr[12:0]`
- `scr_wdata`  out  16  screen store data
- `scr_ready`  in  1  screen side accepts the request this cycle
- `scr_rdata`  in  16  screen load data, sampled in the `scr_valid & scr_ready` cycle
- `kbd_code`  in  8  keyboard scan code, asynchronous to `clk`

## Operation
Address map:
- 0x0000–0x3FFF: RAM.
  - Addresses ≥ `RAM_WORDS` read 0; stores to them are dropped.
- 0x4000–0x5FFF: screen port.
- 0x6000: keyboard.
  - Loads return `{8'h00, kbd_sync}`.
  - Stores are ignored.
- 0x6001–0x7FFF: unmapped.
  - Loads return 0; stores are ignored.

Keyboard path: `kbd_code` passes through a 2-flop synchronizer to produce `kbd_sync`.

FSM states:
- **IDLE**
  - `req_ready` = 1 (forced to 0 while `reset` is high).
  - An accepted RAM, keyboard or unmapped request completes here; the state stays IDLE.
  - An accepted screen request latches write, address and data into the `scr_*` registers, sets `scr_valid` and goes to SCR_WAIT.
- **SCR_WAIT**
  - `req_ready` = 0.
  - The `scr_*` outputs are held stable until `scr_valid & scr_ready`.
  - On that handshake: `scr_valid` drops at the next edge and the state returns to IDLE.
  - If the request was a load, `scr_rdata` is captured into `rsp_rdata` with `rsp_valid` = 1 on the next cycle.

RAM behaviour:
- Synchronous, single port, one read or one write per cycle.
- Contents are not cleared by reset.

Responses:
- Stores never generate `rsp_valid`.
- `rsp_rdata` holds its last value when `rsp_valid` = 0.

## Timing
Reset values:
- `req_ready` = 0 during reset; it is 1 from the first cycle after reset deasserts.
- `rsp_valid` = 0, `rsp_rdata` = 0.
- `scr_valid` = 0, `scr_write` = 0, `scr_addr` = 0, `scr_wdata` = 0.
- `kbd_sync` = 0; state = IDLE.

Latencies:
- RAM, keyboard and unmapped load accepted at edge n: `rsp_valid` is high and `rsp_rdata` valid in cycle n+1.
- RAM store accepted at edge n: memory is updated at edge n.
  - A load of the same address accepted at edge n+1 returns the new data.
- Back-to-back loads are fully pipelined at one per cycle. `rsp_valid` stays high for consecutive cycles.
- Screen request accepted at edge n: `scr_valid` is high from cycle n+1.
  - For a load whose handshake occurs at edge m, `rsp_valid` is high in cycle m+1.
  - Minimum screen load latency is 2 cycles.
  - `req_ready` returns to 1 in cycle m+1.
- Keyboard path latency is 2 clock edges from a `kbd_code` change to `kbd_sync`.

Boundary conditions:
- `req_valid` while `req_ready` = 0: the request is not accepted. The CPU must hold the request.
- `scr_ready` already high in the first SCR_WAIT cycle: the handshake completes at that edge with no extra wait.
- Reset asserted in SCR_WAIT: the transaction is abandoned. `scr_valid` = 0 and no `rsp_valid` follows.
- Reset asserted in the cycle after a load acceptance: `rsp_valid` = 0 and the response is lost.
- Address 0x3FFF with `RAM_WORDS` = 16384 is valid RAM. Address 0x4000 is screen offset 0. Address 0x5FFF is screen offset 0x1FFF.

## Test plan
- **RAM store/load:** store 0xBEEF to 0x0010, then load 0x0010 on the next cycle → `rsp_valid` = 1 one cycle after the load acceptance, with `rsp_rdata` = 0xBEEF.
- **Pipelined loads:** preload 0x0001 = 0x1111 and 0x0002 = 0x2222, then issue loads on consecutive cycles → `rsp_valid` high for 2 consecutive cycles, returning 0x1111 then 0x2222, with `req_ready` constantly 1.
- **Screen store with backpressure:** store 0xA5A5 to 0x4020 with `scr_ready` held low for 3 cycles → `req_ready` = 0 for 4 cycles; `scr_valid` = 1, `scr_write` = 1, `scr_addr` = 0x020 and `scr_wdata` = 0xA5A5 stable throughout; no `rsp_valid`.
- **Screen load:** load 0x5FFF with `scr_ready` = 1 and `scr_rdata` = 0x1234 → `scr_addr` = 0x1FFF, then `rsp_valid` with `rsp_rdata` = 0x1234 exactly 2 cycles after acceptance.
- **Keyboard and unmapped:**
  - Set `kbd_code` = 0x41, wait 2 cycles, load 0x6000 → `rsp_rdata` = 0x0041.
  - Store 0xFFFF to 0x7000, then load 0x7000 → `rsp_rdata` = 0x0000.
- **Reset mid-transaction:** issue a screen load, hold `scr_ready` = 0, then pulse reset for 1 cycle → `scr_valid` = 0 and `rsp_valid` never asserts; `req_ready` = 1 in the cycle after reset deasserts.
